univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//   Parametrised universal register: parallel load, logical/arithmetic shifts, rotates, clear.
//   Successor to the fixed 4-bit load-enable register; adds serial I/O and a shift counter.
//   Used as a serializer/deserializer and general datapath holding register.
// PARAMETERS
//   WIDTH      8    data width in bits, >= 2
//   RESET_VAL  0    value of do after reset, WIDTH bits
// PORTS
//   clk      in   1              clock, all state updates on posedge
//   reset    in   1              reset, synchronous, active-high
//   en       in   1              operation enable; 0 = hold everything
//   mode     in   3              operation select, see BEHAVIOUR
//   di       in   WIDTH          parallel load data
//   sin_l    in   1              serial in, enters do[0] on SHL
//   sin_r    in   1              serial in, enters do[WIDTH-1] on SHR
//   do       out  WIDTH          register contents
//   sout     out  1              registered bit that left the register on last shift/rotate
//   cnt      out  $clog2(WIDTH+1)  shifts since last load/clear, saturates at WIDTH
//   drained  out  1              cnt == WIDTH (combinational from cnt)
//   parity   out  1              XOR of do (see CONFIGURATION)
// BEHAVIOUR
//   Reset: do=RESET_VAL, sout=0, cnt=0, parity=^RESET_VAL (0 when feature off).
//   Priority: reset > en=0 (full hold) > mode.
//   Latency: one cycle. Result visible on do the cycle after the sampling edge.
//   Modes (en=1):
//   - 000 HOLD: no change to do, sout or cnt.
//   - 001 LOAD: do=di; cnt=0; sout=0.
//   - 010 SHL: do={do[W-2:0],sin_l}; sout=old do[W-1].
//   - 011 SHR: do={sin_r,do[W-1:1]}; sout=old do[0].
//   - 100 ROL: do={do[W-2:0],do[W-1]}; sout=old do[W-1].
//   - 101 ROR: do={do[0],do[W-1:1]}; sout=old do[0].
//   - 110 ASR: do={do[W-1],do[W-1:1]}; sout=old do[0].
//   - 111 CLR: do=0; cnt=0; sout=0.
//   - For modes 010..110: cnt=cnt+1, saturating at WIDTH.
//     The shift itself continues after saturation; drained stays 1.
//   - Rotating WIDTH times restores the original do and sets drained=1.
//   - Reset asserted mid-sequence wins in that cycle; no partial update.
//   - Undefined/X mode is not allowed; the bench flags it as an error.
// CONFIGURATION
//   USHR_PARITY_EN defined:
//     parity is a register updated from the NEXT value of do, so it is aligned with do.
//   Not defined:
//     parity is tied to 1'b0. The port list is unchanged in both builds.
// STRUCTURE
//   ushr_pkg holds the mode localparams:
//     MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR, MODE_CLR.
//   Sub-module ushr_cell: one bit. Inputs: 8:1 next-value mux (self, di, left/right neighbour,
//     sin, 0) plus a flop with sync reset to a RESET_VAL bit. Instantiated WIDTH times in a generate loop.
//   Top level holds the cnt, sout and parity logic.
// TESTING (WIDTH=4, RESET_VAL=0)
//   1. reset=1 for 2 cycles -> do=0000, cnt=0, sout=0, drained=0.
//   2. LOAD di=1001, then 4x SHL with sin_l=0:
//      -> sout 1,0,0,1; do=0000; cnt=4; drained=1.
//   3. LOAD 1011, then 4x ROR -> do=1011 after the 4th; cnt=4; sout sequence 1,1,0,1.
//   4. LOAD 1000, ASR x2 -> 1100 then 1110. Then SHR with sin_r=0 -> 0111.
//   5. LOAD 0110, hold mode=SHL with en=0 for 3 cycles -> do=0110, cnt=0.
//      Then CLR -> do=0000, cnt=0.
//   6. SHL in progress (cnt=2), then reset=1 with en=1 -> do=0000, cnt=0 the next cycle.
//      With USHR_PARITY_EN: parity tracks ^do every cycle.

Source files
------------

// File: rtl/ushr_pkg.sv
// Shared definitions for the universal shift register: operation codes and the mode type.
package ushr_pkg;

    localparam int unsigned MODE_W = 3;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_HOLD = 3'b000;
    localparam mode_t MODE_LOAD = 3'b001;
    localparam mode_t MODE_SHL  = 3'b010;
    localparam mode_t MODE_SHR  = 3'b011;
    localparam mode_t MODE_ROL  = 3'b100;
    localparam mode_t MODE_ROR  = 3'b101;
    localparam mode_t MODE_ASR  = 3'b110;
    localparam mode_t MODE_CLR  = 3'b111;

    // True for every mode that moves bits and advances the shift counter.
    function automatic logic is_shift(input mode_t m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/ushr_if.sv
// Control/data bundle of the universal shift register; master drives operations, slave is the register.
interface ushr_if
    import ushr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             en;
    mode_t            mode;
    logic [WIDTH-1:0] di;
    logic             sin_l;
    logic             sin_r;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic [CNT_W-1:0] cnt;
    logic             drained;
    logic             parity;

    modport master (
        output en, mode, di, sin_l, sin_r,
        input  dout, sout, cnt, drained, parity
    );

    modport slave (
        input  en, mode, di, sin_l, sin_r,
        output dout, sout, cnt, drained, parity
    );

endinterface

// File: rtl/ushr_cell.sv
// One bit of the universal shift register: 8:1 next-value mux plus a sync-reset flop.
module ushr_cell
    import ushr_pkg::*;
#(
    parameter logic RST_BIT = 1'b0
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  en,
    input  mode_t mode,
    input  logic  load_d,
    input  logic  shl_d,
    input  logic  shr_d,
    input  logic  rol_d,
    input  logic  ror_d,
    input  logic  asr_d,
    output logic  q
);

    logic nxt_c;

    always_comb begin
        nxt_c = q;
        if (en) begin
            case (mode)
                MODE_HOLD: nxt_c = q;
                MODE_LOAD: nxt_c = load_d;
                MODE_SHL:  nxt_c = shl_d;
                MODE_SHR:  nxt_c = shr_d;
                MODE_ROL:  nxt_c = rol_d;
                MODE_ROR:  nxt_c = ror_d;
                MODE_ASR:  nxt_c = asr_d;
                MODE_CLR:  nxt_c = 1'b0;
                default:   nxt_c = q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q <= RST_BIT;
        else       q <= nxt_c;
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Parametrised universal register with serial I/O and a saturating shift counter.
// Optional registered parity of the contents is enabled with `define USHR_PARITY_EN.
module univ_shift_reg
    import ushr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic    clk,
    input  logic    reset,
    ushr_if.slave   bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] q;
    logic             sout_q;
    logic             sout_nxt;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // Edge bits take serial inputs or wrap-around sources; inner bits take their neighbours.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic shl_d, shr_d, rol_d, ror_d, asr_d;

        if (i == 0) begin : g_lo_edge
            assign shl_d = bus.sin_l;
            assign rol_d = q[WIDTH-1];
        end else begin : g_lo_inner
            assign shl_d = q[i-1];
            assign rol_d = q[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi_edge
            assign shr_d = bus.sin_r;
            assign ror_d = q[0];
            assign asr_d = q[WIDTH-1];
        end else begin : g_hi_inner
            assign shr_d = q[i+1];
            assign ror_d = q[i+1];
            assign asr_d = q[i+1];
        end

        ushr_cell #(
            .RST_BIT (RESET_VAL[i])
        ) u_cell (
            .clk    (clk),
            .reset  (reset),
            .en     (bus.en),
            .mode   (bus.mode),
            .load_d (bus.di[i]),
            .shl_d  (shl_d),
            .shr_d  (shr_d),
            .rol_d  (rol_d),
            .ror_d  (ror_d),
            .asr_d  (asr_d),
            .q      (q[i])
        );
    end

    // Serial-out bit and shift counter next state.
    always_comb begin
        sout_nxt = sout_q;
        cnt_nxt  = cnt_q;
        if (bus.en) begin
            case (bus.mode)
                MODE_LOAD, MODE_CLR: begin
                    sout_nxt = 1'b0;
                    cnt_nxt  = '0;
                end
                MODE_SHL, MODE_ROL: sout_nxt = q[WIDTH-1];
                MODE_SHR, MODE_ROR, MODE_ASR: sout_nxt = q[0];
                default: sout_nxt = sout_q;
            endcase
            if (is_shift(bus.mode) && (cnt_q != CNT_W'(WIDTH)))
                cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sout_q <= sout_nxt;
            cnt_q  <= cnt_nxt;
        end
    end

`ifdef USHR_PARITY_EN
    logic parity_q;
    logic parity_nxt;

    // Parity of the next contents, derived incrementally from the bits entering and leaving.
    always_comb begin
        parity_nxt = parity_q;
        if (bus.en) begin
            case (bus.mode)
                MODE_LOAD: parity_nxt = ^bus.di;
                MODE_SHL:  parity_nxt = parity_q ^ q[WIDTH-1] ^ bus.sin_l;
                MODE_SHR:  parity_nxt = parity_q ^ q[0] ^ bus.sin_r;
                MODE_ASR:  parity_nxt = parity_q ^ q[0] ^ q[WIDTH-1];
                MODE_CLR:  parity_nxt = 1'b0;
                default:   parity_nxt = parity_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) parity_q <= ^RESET_VAL;
        else       parity_q <= parity_nxt;
    end

    assign bus.parity = parity_q;
`else
    assign bus.parity = 1'b0;
`endif

    assign bus.dout    = q;
    assign bus.sout    = sout_q;
    assign bus.cnt     = cnt_q;
    assign bus.drained = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=4): reference model feeds a scoreboard, plus literal checks.
module tb_univ_shift_reg;
    import ushr_pkg::*;

    localparam int unsigned W = 4;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
        logic [2:0]   c;
        logic         dr;
        logic         p;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    exp_t         sb[$];
    logic [W-1:0] m_do;
    logic         m_so;
    logic [2:0]   m_cnt;

    ushr_if #(.WIDTH(W)) bus ();

    univ_shift_reg #(
        .WIDTH     (W),
        .RESET_VAL (4'b0000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then compare DUT against the popped expectation.
    task automatic step(input string tag, input logic r, input logic e, input mode_t m,
                        input logic [W-1:0] d, input logic sl, input logic sr);
        exp_t x;
        reset     = r;
        bus.en    = e;
        bus.mode  = m;
        bus.di    = d;
        bus.sin_l = sl;
        bus.sin_r = sr;
        if (r) begin
            m_do = '0; m_so = 1'b0; m_cnt = '0;
        end else if (e) begin
            case (m)
                MODE_LOAD: begin m_do = d; m_so = 1'b0; m_cnt = '0; end
                MODE_CLR:  begin m_do = '0; m_so = 1'b0; m_cnt = '0; end
                MODE_SHL:  begin m_so = m_do[W-1]; m_do = {m_do[W-2:0], sl}; end
                MODE_SHR:  begin m_so = m_do[0];   m_do = {sr, m_do[W-1:1]}; end
                MODE_ROL:  begin m_so = m_do[W-1]; m_do = {m_do[W-2:0], m_do[W-1]}; end
                MODE_ROR:  begin m_so = m_do[0];   m_do = {m_do[0], m_do[W-1:1]}; end
                MODE_ASR:  begin m_so = m_do[0];   m_do = {m_do[W-1], m_do[W-1:1]}; end
                default: ;
            endcase
            if (m inside {MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR} && m_cnt != 3'd4)
                m_cnt = m_cnt + 3'd1;
        end
        x.d  = m_do;
        x.s  = m_so;
        x.c  = m_cnt;
        x.dr = (m_cnt == 3'd4);
`ifdef USHR_PARITY_EN
        x.p  = ^m_do;
`else
        x.p  = 1'b0;
`endif
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb.pop_front();
            cmp({tag, ".do"},      8'(bus.dout),    8'(x.d));
            cmp({tag, ".sout"},    8'(bus.sout),    8'(x.s));
            cmp({tag, ".cnt"},     8'(bus.cnt),     8'(x.c));
            cmp({tag, ".drained"}, 8'(bus.drained), 8'(x.dr));
            cmp({tag, ".parity"},  8'(bus.parity),  8'(x.p));
        end
    endtask

    initial begin
        reset = 1'b1; bus.en = 1'b0; bus.mode = MODE_HOLD; bus.di = '0;
        bus.sin_l = 1'b0; bus.sin_r = 1'b0;
        m_do = '0; m_so = 1'b0; m_cnt = '0;

        // Reset for two cycles.
        step("rst0", 1, 0, MODE_HOLD, 4'b0000, 0, 0);
        step("rst1", 1, 0, MODE_HOLD, 4'b0000, 0, 0);
        cmp("rst_do", 8'(bus.dout), 8'h0);
        cmp("rst_drained", 8'(bus.drained), 8'h0);

        // LOAD 1001 then 4x SHL with zero serial input.
        step("ld9", 0, 1, MODE_LOAD, 4'b1001, 0, 0);
        step("shl1", 0, 1, MODE_SHL, 4'b0000, 0, 0); cmp("shl1_lit", 8'(bus.sout), 8'h1);
        step("shl2", 0, 1, MODE_SHL, 4'b0000, 0, 0); cmp("shl2_lit", 8'(bus.sout), 8'h0);
        step("shl3", 0, 1, MODE_SHL, 4'b0000, 0, 0); cmp("shl3_lit", 8'(bus.sout), 8'h0);
        step("shl4", 0, 1, MODE_SHL, 4'b0000, 0, 0); cmp("shl4_lit", 8'(bus.sout), 8'h1);
        cmp("shl4_do", 8'(bus.dout), 8'h0);
        cmp("shl4_cnt", 8'(bus.cnt), 8'h4);
        cmp("shl4_drained", 8'(bus.drained), 8'h1);
        // Shift past saturation: counter holds, serial input still enters.
        step("shl5", 0, 1, MODE_SHL, 4'b0000, 1, 0);
        cmp("sat_cnt", 8'(bus.cnt), 8'h4);
        cmp("sat_do", 8'(bus.dout), 8'h1);

        // LOAD 1011 then 4x ROR restores the value.
        step("ldb", 0, 1, MODE_LOAD, 4'b1011, 0, 0);
        cmp("ld_cnt_clr", 8'(bus.cnt), 8'h0);
        step("ror1", 0, 1, MODE_ROR, 4'b0000, 0, 0); cmp("ror1_lit", 8'(bus.sout), 8'h1);
        step("ror2", 0, 1, MODE_ROR, 4'b0000, 0, 0); cmp("ror2_lit", 8'(bus.sout), 8'h1);
        step("ror3", 0, 1, MODE_ROR, 4'b0000, 0, 0); cmp("ror3_lit", 8'(bus.sout), 8'h0);
        step("ror4", 0, 1, MODE_ROR, 4'b0000, 0, 0); cmp("ror4_lit", 8'(bus.sout), 8'h1);
        cmp("ror4_do", 8'(bus.dout), 8'hb);
        cmp("ror4_cnt", 8'(bus.cnt), 8'h4);

        // LOAD 1001 then 4x ROL restores the value.
        step("ld9b", 0, 1, MODE_LOAD, 4'b1001, 0, 0);
        step("rol1", 0, 1, MODE_ROL, 4'b0000, 0, 0); cmp("rol1_lit", 8'(bus.dout), 8'h3);
        step("rol2", 0, 1, MODE_ROL, 4'b0000, 0, 0);
        step("rol3", 0, 1, MODE_ROL, 4'b0000, 0, 0);
        step("rol4", 0, 1, MODE_ROL, 4'b0000, 0, 0); cmp("rol4_do", 8'(bus.dout), 8'h9);

        // Arithmetic shift keeps the sign; logical shift right takes sin_r.
        step("ld8", 0, 1, MODE_LOAD, 4'b1000, 0, 0);
        step("asr1", 0, 1, MODE_ASR, 4'b0000, 0, 1); cmp("asr1_lit", 8'(bus.dout), 8'hc);
        step("asr2", 0, 1, MODE_ASR, 4'b0000, 0, 1); cmp("asr2_lit", 8'(bus.dout), 8'he);
        step("shr1", 0, 1, MODE_SHR, 4'b0000, 1, 0); cmp("shr1_lit", 8'(bus.dout), 8'h7);

        // en=0 holds everything regardless of mode, then clear.
        step("ld6", 0, 1, MODE_LOAD, 4'b0110, 0, 0);
        step("hold1", 0, 0, MODE_SHL, 4'b1111, 1, 1);
        step("hold2", 0, 0, MODE_SHL, 4'b1111, 1, 1);
        step("hold3", 0, 0, MODE_SHL, 4'b1111, 1, 1);
        cmp("hold_do", 8'(bus.dout), 8'h6);
        cmp("hold_cnt", 8'(bus.cnt), 8'h0);
        step("hmode", 0, 1, MODE_HOLD, 4'b1111, 1, 1); cmp("hmode_do", 8'(bus.dout), 8'h6);
        step("clr", 0, 1, MODE_CLR, 4'b1111, 1, 1);
        cmp("clr_do", 8'(bus.dout), 8'h0);

        // Reset mid-shift wins over an enabled operation.
        step("ld3", 0, 1, MODE_LOAD, 4'b0011, 0, 0);
        step("shla", 0, 1, MODE_SHL, 4'b0000, 1, 0);
        step("shlb", 0, 1, MODE_SHL, 4'b0000, 1, 0);
        cmp("mid_cnt", 8'(bus.cnt), 8'h2);
        cmp("mid_sout", 8'(bus.sout), 8'h0);
        step("rstmid", 1, 1, MODE_SHL, 4'b1111, 1, 1);
        cmp("rstmid_do", 8'(bus.dout), 8'h0);
        cmp("rstmid_cnt", 8'(bus.cnt), 8'h0);

        // Random tail exercising every mode against the model.
        for (int i = 0; i < 40; i++) begin
            step("rnd", 0, 1'($urandom_range(0, 7) != 0), mode_t'($urandom_range(0, 7)),
                 4'($urandom), 1'($urandom), 1'($urandom));
        end

        if (sb.size() != 0) begin
            checks++; errors++;
            $error("FAIL sb_drain: observed %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
